// File: rtl/bram_arb_pkg.sv
// Shared types and sizing constants for the BRAM port-B arbiter.
package bram_arb_pkg;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic                 vld;
    logic [ARB_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/bram_arb_rr_pick.sv
// Round-robin picker: rotate requests by rr_ptr, take the first set bit, unrotate.
// Purely combinational; rr_ptr_i must be below NREQ.
module bram_arb_rr_pick
  import bram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]      req_i,
  input  logic [ARB_IDX_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [ARB_IDX_W-1:0] idx_o,
  output logic                 any_o
);

  logic [NREQ-1:0]      rot;
  logic [ARB_IDX_W-1:0] off;
  logic [ARB_IDX_W:0]   sum;
  logic                 found;
  int                   j;

  always_comb begin
    rot   = '0;
    off   = '0;
    sum   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      rot[k] = req_i[j];
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = ARB_IDX_W'(k);
      end
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, off};
    if (sum >= (ARB_IDX_W+1)'(NREQ)) sum = sum - (ARB_IDX_W+1)'(NREQ);
    idx_o = sum[ARB_IDX_W-1:0];
    any_o = found;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = found && (idx_o == ARB_IDX_W'(i));
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with lock for BRAM port B; 0-cycle grant, reads return after RD_LAT.
// Ready is combinational per cycle; optional counters under BRAM_ARB_STATS_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*DATA_W/8-1:0] req_be,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     bram_en,
  output logic [DATA_W/8-1:0]      bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_wdata,
  input  logic [DATA_W-1:0]        bram_rdata
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NREQ*32-1:0]       stat_grants
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ARB_IDX_W-1:0] LAST_IDX = ARB_IDX_W'(NREQ - 1);

  lock_state_t          lock_q, lock_d;
  logic [ARB_IDX_W-1:0] owner_q, owner_d;
  logic [ARB_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  rd_tag_t [RD_LAT-1:0] rd_pipe_q;
  rd_tag_t              rd_tag_d;

  logic [NREQ-1:0]      req_eff;
  logic [NREQ-1:0]      pick_gnt;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 pick_any;
  logic [NREQ-1:0]      gnt;
  logic                 accept;
  logic                 acc_we;
  logic                 acc_lock;

  // While locked, everyone except the owner is masked before the round-robin pick.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_eff[i] = req_valid[i] && ((lock_q == UNLOCKED) || (owner_q == ARB_IDX_W'(i)));
    end
  end

  bram_arb_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i   (req_eff),
    .rr_ptr_i(rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign gnt       = pick_gnt & {NREQ{~reset}};
  assign accept    = pick_any & ~reset;
  assign req_ready = gnt;
  assign bram_en   = accept;

  always_comb begin
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    acc_we     = 1'b0;
    acc_lock   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        bram_we    = req_we[i] ? req_be[i*BE_W +: BE_W] : '0;
        bram_addr  = req_addr[i*ADDR_W +: ADDR_W];
        bram_wdata = req_wdata[i*DATA_W +: DATA_W];
        acc_we     = req_we[i];
        acc_lock   = req_lock[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    owner_d  = owner_q;
    if (accept) begin
      rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
      if (acc_lock) begin
        lock_d  = LOCKED;
        owner_d = pick_idx;
      end else begin
        // Only the owner can be accepted while locked, so any unlocked access releases.
        lock_d = UNLOCKED;
      end
    end
    rd_tag_d.vld = accept && !acc_we;
    rd_tag_d.idx = pick_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= UNLOCKED;
      owner_q   <= '0;
      rd_pipe_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      rd_pipe_q[0] <= rd_tag_d;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe_q[k] <= rd_pipe_q[k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = !reset && rd_pipe_q[RD_LAT-1].vld &&
                     (rd_pipe_q[RD_LAT-1].idx == ARB_IDX_W'(i));
    end
  end

  assign rsp_rdata = reset ? '0 : bram_rdata;

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] cnt_q [NREQ];

  // Clear beats a coincident grant; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset || stat_clr) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
        cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      stat_grants[i*32 +: 32] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed cases plus random traffic against a behavioural model.
module tb_bram_port_arbiter;

  localparam int N   = 2;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready, req_lock = '0, req_we = '0;
  logic [N*BW-1:0] req_be = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            bram_en;
  logic [BW-1:0]   bram_we;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_wdata;
  logic [DW-1:0]   bram_rdata;
`ifdef BRAM_ARB_STATS_EN
  logic            stat_clr = 1'b0;
  logic [N*32-1:0] stat_grants;
`endif

  bram_port_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lock  (req_lock),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
`ifdef BRAM_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // BRAM stand-in, driven only by the DUT's port outputs.
  logic [DW-1:0] bram_mem [0:2047];
  logic [DW-1:0] rd_pipe  [LAT];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we != '0) begin
        for (int b = 0; b < BW; b++)
          if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end else begin
        rd_pipe[0] <= bram_mem[bram_addr];
      end
    end
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_rdata = rd_pipe[LAT-1];

  // Requester-side drive state and the reference model.
  logic [N-1:0]  d_v = '0, d_we = '0, d_lock = '0;
  logic [BW-1:0] d_be    [N];
  logic [AW-1:0] d_addr  [N];
  logic [DW-1:0] d_wdata [N];
  logic [DW-1:0] ref_mem [0:2047];
  int            rr_m = 0, owner_m = -1, g_last = -1;
  logic          exp_vld [LAT];
  int            exp_idx [LAT];
  logic [DW-1:0] exp_dat [LAT];
  int            n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic apply();
    req_valid = d_v;
    req_we    = d_we;
    req_lock  = d_lock;
    for (int i = 0; i < N; i++) begin
      req_be[i*BW +: BW]    = d_be[i];
      req_addr[i*AW +: AW]  = d_addr[i];
      req_wdata[i*DW +: DW] = d_wdata[i];
    end
  endtask

  function automatic int model_pick();
    if (owner_m >= 0) return d_v[owner_m] ? owner_m : -1;
    for (int k = 0; k < N; k++) begin
      if (d_v[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i);
    d_we[i]    = 1'($urandom % 2);
    d_addr[i]  = AW'($urandom % 8);
    d_be[i]    = BW'($urandom);
    d_wdata[i] = $urandom;
    d_lock[i]  = (($urandom % 4) == 0);
  endtask

  // One cycle: check grant and port drive, then the response landing after the edge.
  task automatic step();
    int g;
    logic          nv;
    int            ni;
    logic [DW-1:0] nd;
    apply();
    #1;
    g  = model_pick();
    nv = 1'b0;
    ni = 0;
    nd = '0;
    chk("ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("bram_en", 64'(bram_en), 64'(g >= 0));
    chk("bram_we", 64'(bram_we), (g >= 0 && d_we[g]) ? 64'(d_be[g]) : 64'd0);
    chk("bram_addr", 64'(bram_addr), (g >= 0) ? 64'(d_addr[g]) : 64'd0);
    chk("bram_wdata", 64'(bram_wdata), (g >= 0) ? 64'(d_wdata[g]) : 64'd0);
    if (g >= 0) begin
      rr_m = (g + 1) % N;
      if (d_lock[g]) owner_m = g;
      else if (owner_m == g) owner_m = -1;
      if (d_we[g]) begin
        for (int b = 0; b < BW; b++)
          if (d_be[g][b]) ref_mem[d_addr[g]][8*b +: 8] = d_wdata[g][8*b +: 8];
      end else begin
        nv = 1'b1;
        ni = g;
        nd = ref_mem[d_addr[g]];
      end
    end
    @(posedge clk);
    #1;
    for (int k = LAT - 1; k > 0; k--) begin
      exp_vld[k] = exp_vld[k-1];
      exp_idx[k] = exp_idx[k-1];
      exp_dat[k] = exp_dat[k-1];
    end
    exp_vld[0] = nv;
    exp_idx[0] = ni;
    exp_dat[0] = nd;
    chk("rsp_valid", 64'(rsp_valid), exp_vld[LAT-1] ? (64'd1 << exp_idx[LAT-1]) : 64'd0);
    if (exp_vld[LAT-1]) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_dat[LAT-1]));
    g_last = g;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_v   = '1;
    apply();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_en", 64'(bram_en), 64'd0);
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_wdata", 64'(bram_wdata), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    d_v     = '0;
    rr_m    = 0;
    owner_m = -1;
    for (int k = 0; k < LAT; k++) exp_vld[k] = 1'b0;
    apply();
    #1;
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, idle, k, r0cyc;
    for (int a = 0; a < 2048; a++) begin
      bram_mem[a] = '0;
      ref_mem[a]  = '0;
    end
    bram_mem[5] = 32'h1234;
    ref_mem[5]  = 32'h1234;
    for (int i = 0; i < N; i++) begin
      d_be[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    for (int k2 = 0; k2 < LAT; k2++) exp_vld[k2] = 1'b0;
    do_reset();

    // Single read of a preloaded word.
    d_v = 2'b01; d_we[0] = 1'b0; d_lock = '0; d_addr[0] = 11'd5;
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("t1_rdata", 64'(rsp_rdata), 64'h1234);
    d_v = '0;

    // Both requesting every cycle, unlocked.
    cnt0 = 0; cnt1 = 0; idle = 0;
    d_v = 2'b11;
    for (int i = 0; i < N; i++) begin rand_req(i); d_lock[i] = 1'b0; end
    for (int c = 0; c < 8; c++) begin
      step();
      if (g_last == 0) cnt0++;
      else if (g_last == 1) cnt1++;
      else idle++;
      if (g_last >= 0) begin rand_req(g_last); d_lock[g_last] = 1'b0; end
    end
    chk("t2_cnt0", 64'(cnt0), 64'd4);
    chk("t2_cnt1", 64'(cnt1), 64'd4);
    chk("t2_idle", 64'(idle), 64'd0);
    d_v = '0;

    // Locked write burst by req1 while req0 waits.
    if (rr_m != 1) begin
      d_v = 2'b01; d_we[0] = 1'b0; d_lock[0] = 1'b0; d_addr[0] = '0;
      step();
    end
    d_v = 2'b11;
    d_we[0] = 1'b0; d_lock[0] = 1'b0; d_addr[0] = 11'd9;
    k = 0; r0cyc = -1;
    d_we[1] = 1'b1; d_be[1] = 4'hF; d_addr[1] = 11'd0; d_wdata[1] = $urandom; d_lock[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (g_last == 1) begin
        k++;
        if (k == 4) d_v[1] = 1'b0;
        else begin
          d_addr[1] = AW'(k); d_wdata[1] = $urandom; d_lock[1] = (k < 3);
        end
      end else if (g_last == 0) begin
        r0cyc = c;
        break;
      end
    end
    chk("t3_req0_cycle", 64'(r0cyc), 64'd5);
    d_v = '0;

    // Write then read of the same address from different requesters.
    d_v = 2'b01; d_we[0] = 1'b1; d_be[0] = 4'hF; d_addr[0] = 11'd7;
    d_wdata[0] = 32'hDEADBEEF; d_lock = '0;
    step();
    d_v = 2'b10; d_we[1] = 1'b0; d_addr[1] = 11'd7;
    step();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'b10);
    chk("t4_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    d_v = '0;

    // Reset with a read in flight.
    d_v = 2'b01; d_we[0] = 1'b0; d_addr[0] = 11'd7;
    step();
    d_v = 2'b10; d_we[1] = 1'b0; d_addr[1] = 11'd5;
    apply();
    #1;
    chk("t5_ready", 64'(req_ready), 64'b10);
    @(posedge clk);
    #1;
    do_reset();
    d_v = 2'b11; d_we = 2'b00; d_lock = '0; d_addr[0] = 11'd1; d_addr[1] = 11'd2;
    step();
    chk("t5_first_grant", 64'(g_last), 64'd0);
    d_v = '0;

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!d_v[i]) begin
          if (($urandom % 10) < 6) begin d_v[i] = 1'b1; rand_req(i); end
          else d_lock[i] = 1'($urandom % 2);
        end
      end
      step();
      if (g_last >= 0) d_v[g_last] = 1'b0;
    end

`ifdef BRAM_ARB_STATS_EN
    do_reset();
    d_v = 2'b01;
    for (int n = 1; n <= 10; n++) begin
      rand_req(0);
      d_lock[0] = 1'b0;
      stat_clr  = (n == 6);
      step();
      stat_clr  = 1'b0;
    end
    d_v = '0;
    chk("t6_grants0", 64'(stat_grants[31:0]), 64'd4);
    chk("t6_grants1", 64'(stat_grants[63:32]), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
